// File: rtl/lfsr_rr_arbiter.sv
// lfsr_rr_arbiter: one Fibonacci LFSR shared by NREQ requesters.
// Round-robin grant, bursts of up to BURST words, guarded seed-load path.
module lfsr_rr_arbiter #(
    parameter int unsigned   W     = 4,
    parameter logic [W-1:0]  TAPS  = 4'b0011,
    parameter logic [W-1:0]  SEED  = 'd1,
    parameter int unsigned   NREQ  = 4,
    parameter int unsigned   BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            rnd_valid,
    output logic [W-1:0]    rnd_data,
    output logic            busy,
    input  logic            seed_we,
    input  logic [W-1:0]    seed_data,
    output logic            seed_ready,
    output logic            seed_err
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned BW = $clog2(BURST + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SERVE,
        ST_SEED
    } state_t;

    state_t          state_q;
    logic [W-1:0]    lfsr_q;
    logic [W-1:0]    seed_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   winner_q;
    logic [BW-1:0]   beat_q;
    logic [NREQ-1:0] gnt_q;
    logic            seed_err_q;

    logic [W-1:0]    lfsr_step;
    logic [W-1:0]    lfsr_d;
    logic [PW-1:0]   winner_d;
    logic            win_found;
    logic [PW:0]     cand;
    logic [PW-1:0]   ptr_d;
    logic [BW-1:0]   beat_d;
    logic            last_beat;

    // Next LFSR word; an all-zero result would lock up, so fall back to SEED.
    always_comb begin
        lfsr_step = {^(lfsr_q & TAPS), lfsr_q[W-1:1]};
        lfsr_d    = (lfsr_step == '0) ? SEED : lfsr_step;
    end

    // Round-robin pick: first set request scanning ptr, ptr+1, ... modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        winner_d  = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(i);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (!win_found && req[cand[PW-1:0]]) begin
                win_found = 1'b1;
                winner_d  = cand[PW-1:0];
            end
        end
    end

    // Pointer successor of the current winner and burst beat bookkeeping.
    always_comb begin
        ptr_d     = (winner_q == PW'(NREQ - 1)) ? '0 : winner_q + PW'(1);
        beat_d    = beat_q + BW'(1);
        last_beat = (beat_d == BW'(BURST));
    end

    // Arbiter FSM with registered grant, pointer, LFSR and seed error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            lfsr_q     <= SEED;
            seed_q     <= SEED;
            ptr_q      <= '0;
            winner_q   <= '0;
            beat_q     <= '0;
            gnt_q      <= '0;
            seed_err_q <= 1'b0;
        end else begin
            seed_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (seed_we) begin
                        seed_q     <= seed_data;
                        // Raised here so the pulse coincides with the SEED cycle.
                        seed_err_q <= (seed_data == '0);
                        state_q    <= ST_SEED;
                    end else if (win_found) begin
                        winner_q <= winner_d;
                        gnt_q    <= NREQ'(1) << winner_d;
                        beat_q   <= '0;
                        state_q  <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (req[winner_q]) begin
                        lfsr_q <= lfsr_d;
                        beat_q <= beat_d;
                        if (last_beat) begin
                            gnt_q   <= '0;
                            ptr_q   <= ptr_d;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        gnt_q   <= '0;
                        ptr_q   <= ptr_d;
                        state_q <= ST_IDLE;
                    end
                end
                ST_SEED: begin
                    lfsr_q  <= (seed_q == '0) ? SEED : seed_q;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt        = gnt_q;
    assign rnd_data   = lfsr_q;
    assign rnd_valid  = (state_q == ST_SERVE) && req[winner_q];
    assign seed_ready = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign seed_err   = seed_err_q;

endmodule

// File: tb/tb_lfsr_rr_arbiter.sv
// Scoreboard bench for lfsr_rr_arbiter with default parameters.
module tb_lfsr_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       rnd_valid;
    logic [3:0] rnd_data;
    logic       busy;
    logic       seed_we;
    logic [3:0] seed_data;
    logic       seed_ready;
    logic       seed_err;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Expected {gnt, word} for each delivered beat, in delivery order.
    logic [31:0] sb_q[$];
    int unsigned m_idx = 0;

    // Period-15 sequence of the default LFSR starting from 0001.
    logic [3:0] SEQ [15] = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b1001,
                             4'b1100, 4'b0110, 4'b1011, 4'b0101, 4'b1010,
                             4'b1101, 4'b1110, 4'b1111, 4'b0111, 4'b0011};

    lfsr_rr_arbiter #(
        .W     (4),
        .TAPS  (4'b0011),
        .SEED  (4'b0001),
        .NREQ  (4),
        .BURST (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .gnt        (gnt),
        .rnd_valid  (rnd_valid),
        .rnd_data   (rnd_data),
        .busy       (busy),
        .seed_we    (seed_we),
        .seed_data  (seed_data),
        .seed_ready (seed_ready),
        .seed_err   (seed_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_words(input logic [3:0] g, input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            sb_q.push_back(32'({g, SEQ[m_idx]}));
            m_idx = (m_idx + 1) % 15;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        seed_we = 1'b0;
        seed_data = '0;
        cyc(2);
        rst = 1'b1;
        m_idx = 0;
    endtask

    // Every delivered word is matched against the scoreboard head.
    always @(negedge clk) begin
        if (rst && rnd_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                chk("sb_word", 32'({gnt, rnd_data}), sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        do_reset();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_valid", 32'(rnd_valid), 32'h0);
        chk("rst_data", 32'(rnd_data), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_seedrdy", 32'(seed_ready), 32'h1);
        chk("rst_seederr", 32'(seed_err), 32'h0);

        // Single requester held: two bursts of 4 with one idle cycle between
        req = 4'b0001;
        push_words(4'b0001, 8);
        cyc(1);
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_busy", 32'(busy), 32'h1);
        cyc(4);
        chk("t1_idle_gnt", 32'(gnt), 32'h0);
        chk("t1_idle_valid", 32'(rnd_valid), 32'h0);
        cyc(1);
        chk("t1_regrant", 32'(gnt), 32'h1);
        chk("t1_word5", 32'(rnd_data), 32'b1001);
        cyc(4);
        req = '0;
        cyc(2);
        chk("t1_sb_empty", 32'(sb_q.size()), 32'd0);

        // All requesting from ptr=0: rotation 0,1,2,3,0
        do_reset();
        req = 4'b1111;
        for (int unsigned k = 0; k < 5; k++) begin
            push_words(4'(4'b0001 << (k % 4)), 4);
        end
        cyc(6);
        chk("t2_gnt2", 32'(gnt), 32'h2);
        cyc(19);
        req = '0;
        cyc(2);
        chk("t2_sb_empty", 32'(sb_q.size()), 32'd0);

        // Early termination of requester 0 after 2 beats, then requester 2
        do_reset();
        req = 4'b0101;
        push_words(4'b0001, 2);
        cyc(3);
        req = 4'b0100;
        #1;
        chk("t3_drop_valid", 32'(rnd_valid), 32'h0);
        chk("t3_drop_data", 32'(rnd_data), 32'b0100);
        cyc(1);
        chk("t3_end_gnt", 32'(gnt), 32'h0);
        push_words(4'b0100, 4);
        cyc(5);
        req = '0;
        cyc(2);
        chk("t3_sb_empty", 32'(sb_q.size()), 32'd0);

        // Seed write wins over a simultaneous request (ptr is now 3)
        chk("t4_seedrdy", 32'(seed_ready), 32'h1);
        seed_we = 1'b1;
        seed_data = 4'b1011;
        req = 4'b0010;
        cyc(1);
        seed_we = 1'b0;
        chk("t4_seed_busy", 32'(busy), 32'h1);
        chk("t4_seed_rdy", 32'(seed_ready), 32'h0);
        chk("t4_seed_gnt", 32'(gnt), 32'h0);
        chk("t4_seed_err", 32'(seed_err), 32'h0);
        cyc(1);
        chk("t4_loaded", 32'(rnd_data), 32'b1011);
        m_idx = 7;
        push_words(4'b0010, 4);
        cyc(5);
        req = '0;
        cyc(2);
        chk("t4_sb_empty", 32'(sb_q.size()), 32'd0);

        // Zero seed rejected, then seed_we during SERVE ignored (ptr is now 2)
        seed_we = 1'b1;
        seed_data = 4'b0000;
        cyc(1);
        seed_we = 1'b0;
        chk("t5_err_pulse", 32'(seed_err), 32'h1);
        cyc(1);
        chk("t5_err_clear", 32'(seed_err), 32'h0);
        chk("t5_fallback", 32'(rnd_data), 32'b0001);
        m_idx = 0;
        req = 4'b0001;
        push_words(4'b0001, 4);
        cyc(2);
        seed_we = 1'b1;
        seed_data = 4'b1111;
        chk("t5_serve_rdy", 32'(seed_ready), 32'h0);
        cyc(1);
        seed_we = 1'b0;
        cyc(2);
        req = '0;
        cyc(1);
        chk("t5_ignored", 32'(rnd_data), 32'(SEQ[m_idx]));
        chk("t5_sb_empty", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset mid-burst after 2 beats (ptr is now 1)
        req = 4'b0001;
        push_words(4'b0001, 2);
        cyc(3);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_gnt", 32'(gnt), 32'h0);
        chk("t6_valid", 32'(rnd_valid), 32'h0);
        chk("t6_data", 32'(rnd_data), 32'b0001);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_sb_empty", 32'(sb_q.size()), 32'd0);
        req = '0;
        cyc(1);
        rst = 1'b1;
        m_idx = 0;
        // Requesters 0 and 1 both asking: ptr=0 means requester 0 wins
        req = 4'b0011;
        push_words(4'b0001, 4);
        cyc(1);
        chk("t6_regrant", 32'(gnt), 32'h1);
        chk("t6_first", 32'(rnd_data), 32'b0001);
        cyc(4);
        req = '0;
        cyc(3);
        chk("t6_sb_final", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_rr_arbiter.md
Name: lfsr_rr_arbiter

Overview:
- Shares one Fibonacci LFSR pseudo-random source among NREQ requesters.
- Round-robin arbitration; the winner holds the source for a burst of up to BURST words.
- Provides a seed-load path with zero-seed protection.
- Sits between the LFSR datapath and the blocks that consume random words, such as scramblers and test-pattern sources.

Parameters:
- W, 4: LFSR width in bits (W>=2).
- TAPS, 4'b0011: feedback mask; fb = XOR-reduce(state & TAPS).
- SEED, 1: reset and fallback seed; must be nonzero.
- NREQ, 4: number of requesters (NREQ>=2).
- BURST, 4: maximum words per grant (>=1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request level.
- gnt  out  NREQ  one-hot grant; all zero when no grant.
- rnd_valid  out  1  word on rnd_data is consumed by the granted requester this cycle.
- rnd_data  out  W  current LFSR state.
- busy  out  1  high in SERVE or SEED.
- seed_we  in  1  seed write strobe.
- seed_data  in  W  seed value.
- seed_ready  out  1  high only in IDLE; seed_we is accepted only when it is high.
- seed_err  out  1  one-cycle pulse: zero seed rejected.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - state=IDLE, lfsr=SEED, ptr=0, beat=0
  - gnt=0, rnd_valid=0, seed_err=0
  - busy=0, seed_ready=1
- LFSR step: lfsr <= {fb, lfsr[W-1:1]}.
  - Advances only on a cycle where rnd_valid=1. It never advances otherwise.
  - Defaults give period 15 from 0001: 0001,1000,0100,0010,1001,1100,0110,1011,0101,1010,1101,1110,1111,0111,0011, then back to 0001.
- rnd_data is always the registered lfsr state.
- FSM states: IDLE, SERVE, SEED.
- IDLE:
  - If seed_we=1, go to SEED. Seed has priority over req in the same cycle.
  - Else if req!=0, pick the winner: the first set bit scanning ptr, ptr+1, ... modulo NREQ.
  - Then register gnt=onehot(winner), clear beat, and go to SERVE. The grant is visible the cycle after req is sampled.
  - Else stay in IDLE.
- SERVE:
  - rnd_valid = req[winner] (combinational). gnt is held constant.
  - If req[winner]=1: deliver a word, advance lfsr, beat++.
  - When beat reaches BURST, the word just delivered was the last one. Next cycle: IDLE, gnt=0, ptr=(winner+1) mod NREQ.
  - If req[winner]=0: no word, no LFSR step. Next cycle: IDLE, gnt=0, ptr=(winner+1) mod NREQ. This is early termination.
  - Requests from other requesters during SERVE have no effect until IDLE.
- Minimum one IDLE cycle between consecutive grants. A continuously requesting single requester therefore receives BURST words every BURST+1 cycles.
- SEED (one cycle):
  - The seed_data captured in IDLE is loaded into lfsr.
  - If the captured seed is zero, load SEED instead and pulse seed_err during the SEED cycle.
  - Return to IDLE. ptr is unchanged.
- seed_we while seed_ready=0 is ignored. It is not queued.
- Reset asserted mid-SERVE or mid-SEED: immediate return to reset values. No partial word is delivered and no seed is loaded.
- The LFSR state is never zero in operation. Any seed path that would produce zero loads SEED.
- Sizes:
  - ptr is ceil(log2(NREQ)) bits, wrapping modulo NREQ; this must also hold for non-power-of-2 NREQ.
  - beat is wide enough to hold BURST.

Test Plan:
- Reset, then req=0001 held.
  - gnt=0001 one cycle later.
  - rnd_data 0001,1000,0100,0010 on 4 valid beats.
  - Then gnt=0 for one cycle, then the next burst starts at 1001.
- req=1111 held from IDLE with ptr=0.
  - Grants rotate 0001,0010,0100,1000,0001, each lasting 4 beats with one IDLE cycle between.
  - No requester is starved.
- req=0101, then req[0] drops after 2 beats.
  - Requester 0 gets 0001,1000; the grant ends with no LFSR step.
  - The next grant goes to requester 2, starting at word 0100.
- In IDLE, seed_we=1 with seed_data=1011 and req=0010 in the same cycle.
  - SEED state; lfsr=1011; no seed_err.
  - Then requester 1 is granted, first word 1011, second 0101.
- seed_we with seed_data=0000.
  - seed_err pulses for one cycle and lfsr=0001.
  - seed_we asserted during SERVE is ignored: lfsr continues its sequence.
- rst=0 asserted mid-burst after 2 beats (asynchronous).
  - gnt=0, rnd_valid=0, lfsr=0001, ptr=0 immediately.
  - After release, req=0001 gets word 0001 again.
